dec_key_scheduler: RTL and testbench

AES-128 round-key source for the decryption datapath. Accepts a 128-bit cipher key and expands it into all eleven round keys, one round per cycle, into an internal key bank. It then serves the keys to the decryption core in reverse order, rk10 down to rk0, one key per `req_key` request. It sits directly upstream of the decryption core: the core's `ready_dec` output drives `req_key`, and `round_key` drives the core's `key_in`.

---
 rtl/dec_key_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_dec_key_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec_key_scheduler.sv
// dec_key_scheduler
// -----------------
// AES-128 round-key source for the decryption datapath. A cipher key is
// expanded into all eleven round keys (one round per clock) into an internal
// bank. The keys are then handed to the decryption core in reverse order,
// rk10 down to rk0, advancing one key per req_key. After rk0 the pointer
// wraps back to rk10, so the next block under the same key starts over.
//
// Parameters:
//   EQUIV_INV  - 1: rk1..rk9 are presented as InvMixColumns(rk), matching the
//                equivalent inverse cipher. rk0/rk10 are never transformed.
//
// Ports:
//   clk         in   1    rising-edge clock
//   reset       in   1    asynchronous, active-high reset
//   key_load    in   1    cipher key valid, taken when key_ready=1
//   cipher_key  in   128  cipher key, [127:96]=w0 ... [31:0]=w3
//   key_ready   out  1    a new key can be accepted (IDLE or SERVE)
//   req_key     in   1    consumer took round_key, advance to next key
//   round_key   out  128  current round key, 0 when keys_avail=0
//   keys_avail  out  1    round_key is valid
//   last_key    out  1    round_key is rk0
//   busy        out  1    key expansion in progress

module dec_key_scheduler #(
  parameter int EQUIV_INV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  output logic         key_ready,
  input  logic         req_key,
  output logic [127:0] round_key,
  output logic         keys_avail,
  output logic         last_key,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    SERVE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_nextState;

  logic [127:0]   r_bank [0:10];
  logic [3:0]     r_round;
  logic [3:0]     r_ptr;
  logic [7:0]     r_rcon;

  logic           w_accept;
  logic [3:0]     w_prevIdx;
  logic [127:0]   w_prevKey;
  logic [31:0]    w_rotWord;
  logic [31:0]    w_subWord;
  logic [31:0]    w_temp;
  logic [127:0]   w_nextKey;
  logic [7:0]     w_rconNext;
  logic [127:0]   w_servedKey;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box computed as the multiplicative inverse (x^254, which maps
  // 0 to 0) followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31;
    logic [7:0] x62, x63, x126, x127, inv;
    x2   = gfMul(x, x);
    x3   = gfMul(x2, x);
    x6   = gfMul(x3, x3);
    x7   = gfMul(x6, x);
    x14  = gfMul(x7, x7);
    x15  = gfMul(x14, x);
    x30  = gfMul(x15, x15);
    x31  = gfMul(x30, x);
    x62  = gfMul(x31, x31);
    x63  = gfMul(x62, x);
    x126 = gfMul(x63, x63);
    x127 = gfMul(x126, x);
    inv  = gfMul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // InvMixColumns on all four columns of a 128-bit state/key.
  function automatic logic [127:0] invMixKey(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = k[127-32*c -: 8];
      a1 = k[119-32*c -: 8];
      a2 = k[111-32*c -: 8];
      a3 = k[103-32*c -: 8];
      r[127-32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
      r[119-32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
      r[111-32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
      r[103-32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
    end
    return r;
  endfunction

  // A key is taken in any state except EXPAND; a load during expansion is dropped.
  assign w_accept = key_load && (r_state != EXPAND);

  // One expansion round: derive bank[r] from bank[r-1] using the four shared
  // S-boxes on RotWord(w3), then chain the XORs across the four words.
  always_comb begin
    w_prevIdx  = (r_round == 4'd0) ? 4'd0 : (r_round - 4'd1);
    w_prevKey  = r_bank[w_prevIdx];
    w_rotWord  = {w_prevKey[23:0], w_prevKey[31:24]};
    w_subWord  = {sbox(w_rotWord[31:24]), sbox(w_rotWord[23:16]),
                  sbox(w_rotWord[15:8]),  sbox(w_rotWord[7:0])};
    w_temp     = w_subWord ^ {r_rcon, 24'h000000};
    w_nextKey[127:96] = w_prevKey[127:96] ^ w_temp;
    w_nextKey[95:64]  = w_prevKey[95:64]  ^ w_nextKey[127:96];
    w_nextKey[63:32]  = w_prevKey[63:32]  ^ w_nextKey[95:64];
    w_nextKey[31:0]   = w_prevKey[31:0]   ^ w_nextKey[63:32];
    w_rconNext = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A load in SERVE takes priority over a key request.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (key_load)             w_nextState = EXPAND;
      EXPAND:  if (r_round == 4'd10)     w_nextState = SERVE;
      SERVE:   if (key_load)             w_nextState = EXPAND;
      default:                           w_nextState = IDLE;
    endcase
  end

  // Key bank, round counter, Rcon and serve pointer. The round that writes
  // rk10 also parks the pointer on rk10 for the first served key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 11; i++) r_bank[i] <= '0;
      r_round <= 4'd0;
      r_ptr   <= 4'd0;
      r_rcon  <= 8'h00;
    end else if (w_accept) begin
      r_bank[0] <= cipher_key;
      r_round   <= 4'd1;
      r_rcon    <= 8'h01;
    end else if (r_state == EXPAND) begin
      r_bank[r_round] <= w_nextKey;
      r_rcon          <= w_rconNext;
      if (r_round == 4'd10) begin
        r_ptr <= 4'd10;
      end else begin
        r_round <= r_round + 4'd1;
      end
    end else if ((r_state == SERVE) && req_key) begin
      r_ptr <= (r_ptr == 4'd0) ? 4'd10 : (r_ptr - 4'd1);
    end
  end

  // Outputs decoded from state; the served key is a mux out of the bank.
  always_comb begin
    key_ready   = (r_state != EXPAND);
    busy        = (r_state == EXPAND);
    keys_avail  = (r_state == SERVE);
    last_key    = (r_state == SERVE) && (r_ptr == 4'd0);
    w_servedKey = r_bank[r_ptr];
    round_key   = '0;
    if (r_state == SERVE) begin
      if ((EQUIV_INV != 0) && (r_ptr != 4'd0) && (r_ptr != 4'd10)) begin
        round_key = invMixKey(w_servedKey);
      end else begin
        round_key = w_servedKey;
      end
    end
  end

endmodule

// File: tb/tb_dec_key_scheduler.sv
// tb_dec_key_scheduler
// --------------------
// Directed bench for dec_key_scheduler. Two instances share all inputs: one
// with EQUIV_INV=0 (plain keys) and one with EQUIV_INV=1 (InvMixColumns on
// rk1..rk9). The transformed keys are checked by applying forward
// MixColumns to them and comparing against the FIPS-197 expansion.

module tb_dec_key_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         keyLoad;
  logic [127:0] cipherKey;
  logic         reqKey;

  logic         keyReady0, keysAvail0, lastKey0, busy0;
  logic [127:0] roundKey0;
  logic         keyReady1, keysAvail1, lastKey1, busy1;
  logic [127:0] roundKey1;

  int numCompared   = 0;
  int numMismatched = 0;

  logic [127:0] golden [0:10];

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] OTHER_KEY  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  dec_key_scheduler #(.EQUIV_INV(0)) dutPlain (
    .clk        (clk),
    .reset      (reset),
    .key_load   (keyLoad),
    .cipher_key (cipherKey),
    .key_ready  (keyReady0),
    .req_key    (reqKey),
    .round_key  (roundKey0),
    .keys_avail (keysAvail0),
    .last_key   (lastKey0),
    .busy       (busy0)
  );

  dec_key_scheduler #(.EQUIV_INV(1)) dutEquiv (
    .clk        (clk),
    .reset      (reset),
    .key_load   (keyLoad),
    .cipher_key (cipherKey),
    .key_ready  (keyReady1),
    .req_key    (reqKey),
    .round_key  (roundKey1),
    .keys_avail (keysAvail1),
    .last_key   (lastKey1),
    .busy       (busy1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic load, input logic [127:0] key, input logic req);
    keyLoad   = load;
    cipherKey = key;
    reqKey    = req;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns, the inverse of what the EQUIV_INV instance applies.
  function automatic logic [127:0] mixKey(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = k[127-32*c -: 8];
      a1 = k[119-32*c -: 8];
      a2 = k[111-32*c -: 8];
      a3 = k[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_key_ready"},  128'(keyReady0),  128'd1);
    checkOutput({tag, "_round_key"},  roundKey0,        128'd0);
    checkOutput({tag, "_keys_avail"}, 128'(keysAvail0), 128'd0);
    checkOutput({tag, "_last_key"},   128'(lastKey0),   128'd0);
    checkOutput({tag, "_busy"},       128'(busy0),      128'd0);
    checkOutput({tag, "_equiv_rk"},   roundKey1,        128'd0);
  endtask

  // Check both instances against golden key i.
  task automatic checkKey(input string tag, input int i);
    checkOutput($sformatf("%s_plain_rk%0d", tag, i), roundKey0, golden[i]);
    if (i == 0 || i == 10) begin
      checkOutput($sformatf("%s_equiv_rk%0d", tag, i), roundKey1, golden[i]);
    end else begin
      checkOutput($sformatf("%s_equiv_mix_rk%0d", tag, i), mixKey(roundKey1), golden[i]);
    end
  endtask

  initial begin
    int gap;

    golden[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    golden[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    golden[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    golden[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    golden[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    golden[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    golden[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    golden[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    golden[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    golden[9]  = 128'hac7766f319fadc2128d12941575c006e;
    golden[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Power-on reset.
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    #2;
    checkResetState("por");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Load the FIPS key; during expansion pulse req_key and try a second load.
    applyStimulus(1'b1, FIPS_KEY, 1'b0);
    tick();
    applyStimulus(1'b0, FIPS_KEY, 1'b0);
    checkOutput("e0_busy",       128'(busy0),      128'd1);
    checkOutput("e0_key_ready",  128'(keyReady0),  128'd0);
    checkOutput("e0_keys_avail", 128'(keysAvail0), 128'd0);
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(c == 6, (c == 6) ? OTHER_KEY : FIPS_KEY, (c == 3) || (c == 4));
      tick();
    end
    applyStimulus(1'b0, FIPS_KEY, 1'b0);
    checkOutput("e9_keys_avail", 128'(keysAvail0), 128'd0);
    checkOutput("e9_busy",       128'(busy0),      128'd1);
    checkOutput("e9_round_key",  roundKey0,        128'd0);
    tick();
    checkOutput("e10_keys_avail", 128'(keysAvail0), 128'd1);
    checkOutput("e10_busy",       128'(busy0),      128'd0);
    checkOutput("e10_key_ready",  128'(keyReady0),  128'd1);
    checkOutput("e10_last_key",   128'(lastKey0),   128'd0);

    // Sustained requests: rk10 .. rk0, then wrap to rk10.
    reqKey = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      checkKey("burst", i);
      checkOutput($sformatf("burst_last_rk%0d", i), 128'(lastKey0), 128'(i == 0));
      tick();
    end
    reqKey = 1'b0;
    checkKey("wrap", 10);
    checkOutput("wrap_last_key", 128'(lastKey0), 128'd0);

    // Gapped requests: key must hold between requests, order preserved.
    for (int i = 10; i >= 0; i--) begin
      checkKey("gap", i);
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        tick();
        checkOutput($sformatf("gap_hold_rk%0d", i), roundKey0, golden[i]);
      end
      reqKey = 1'b1;
      tick();
      reqKey = 1'b0;
    end
    checkKey("gap_wrap", 10);

    // Walk to rk5, then load the all-zero key together with a request.
    reqKey = 1'b1;
    repeat (5) tick();
    reqKey = 1'b0;
    checkKey("pre_sim", 5);
    applyStimulus(1'b1, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("sim_busy",       128'(busy0),      128'd1);
    checkOutput("sim_keys_avail", 128'(keysAvail0), 128'd0);
    checkOutput("sim_round_key",  roundKey0,        128'd0);
    repeat (9) tick();
    checkOutput("sim_e9_keys_avail", 128'(keysAvail0), 128'd0);
    tick();
    checkOutput("sim_e10_keys_avail", 128'(keysAvail0), 128'd1);
    checkOutput("zero_plain_rk10",    roundKey0,        ZERO_RK10);
    checkOutput("zero_equiv_rk10",    roundKey1,        ZERO_RK10);

    // Asynchronous reset between edges while serving.
    reqKey = 1'b1;
    repeat (3) tick();
    reqKey = 1'b0;
    checkOutput("pre_rst_keys_avail", 128'(keysAvail0), 128'd1);
    #2;
    reset = 1'b1;
    #1;
    checkResetState("async_rst");
    #3;
    reset = 1'b0;
    tick();
    checkResetState("post_rst");

    // Requests in IDLE are ignored.
    reqKey = 1'b1;
    tick();
    reqKey = 1'b0;
    checkResetState("idle_req");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
